// File: rtl/qspi_pkg.sv
// Shared types and constants for the Quad I/O Fast Read (0xEB) responder.
package qspi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_MODE,
      ST_DUMMY,
      ST_DATA,
      ST_IGNORE
   } qspi_state_e;

   localparam logic [7:0] CMD_QIOR     = 8'hEB;
   localparam int         CMD_CYC      = 8;
   localparam int         ADDR_CYC     = 6;
   localparam int         MODE_CYC     = 2;
   localparam logic [3:0] CONT_NIB_DEF = 4'hA;

endpackage

// File: rtl/qspi_byte_prefetch.sv
// Byte pipeline for the data phase: holds the byte being shifted out, the
// prefetched next byte and the byte pointer, and owns the memory read port.
module qspi_byte_prefetch
   import qspi_pkg::*;
#(
   parameter int ADDR_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              abort,
   input  logic              start,
   input  logic              fetch,
   input  logic              advance,
   input  logic              nib_hi,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [7:0]        mem_rdata,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        nibble
);

   logic [7:0]        cur_byte;
   logic [7:0]        next_byte;
   logic [ADDR_W-1:0] ptr;
   logic              rd_pend;
   logic              rd_to_cur;

   assign nibble = nib_hi ? cur_byte[7:4] : cur_byte[3:0];

   // Issue single-cycle reads, land returning data one clk after the strobe,
   // and forward it straight into cur_byte when it arrives on an advance edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_byte  <= 8'h00;
         next_byte <= 8'h00;
         ptr       <= '0;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         rd_pend   <= 1'b0;
         rd_to_cur <= 1'b0;
      end else begin
         mem_rd  <= 1'b0;
         rd_pend <= 1'b0;
         if (abort) begin
            rd_to_cur <= 1'b0;
         end else begin
            rd_pend <= mem_rd;
            if (rd_pend) begin
               if (rd_to_cur) cur_byte  <= mem_rdata;
               else           next_byte <= mem_rdata;
            end
            if (start) begin
               ptr       <= start_addr;
               mem_addr  <= start_addr;
               mem_rd    <= 1'b1;
               rd_to_cur <= 1'b1;
            end else if (fetch) begin
               mem_addr  <= ptr + ADDR_W'(1);
               mem_rd    <= 1'b1;
               rd_to_cur <= 1'b0;
            end
            if (advance) begin
               cur_byte <= (rd_pend && !rd_to_cur) ? mem_rdata : next_byte;
               ptr      <= ptr + ADDR_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/qspi_flash_responder.sv
// Target end of the Quad I/O Fast Read link: decodes command, address, mode
// and dummy phases from sck/ce_n/io and streams nibbles from backing memory.
module qspi_flash_responder
   import qspi_pkg::*;
#(
   parameter int         ADDR_W    = 24,
   parameter logic [3:0] CONT_NIB  = CONT_NIB_DEF,
   parameter int         DUMMY_CYC = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sck,
   input  logic              ce_n,
   input  logic [3:0]        io_in,
   output logic [3:0]        io_out,
   output logic              io_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   output logic              cont_mode,
   output logic              cmd_err
);

   qspi_state_e       state, state_next;
   logic              ev;
   logic              last;
   logic              cmd_ok;
   logic              start, fetch, advance, cmd_bad;
   logic [3:0]        cnt;
   int                phase_len;
   logic [6:0]        cmd_sr;
   logic [ADDR_W-1:0] saddr;
   logic [3:0]        mode_hi;
   logic              nib_hi;
   logic [3:0]        nibble;

   assign ev     = ~ce_n & sck;
   assign cmd_ok = ({cmd_sr, io_in[0]} == CMD_QIOR);
   assign io_oe  = (state == ST_DATA) & ~ce_n;
   assign io_out = io_oe ? nibble : 4'h0;

   // Length of the current counted phase and whether this is its final event.
   always_comb begin
      phase_len = 1;
      case (state)
         ST_CMD:   phase_len = CMD_CYC;
         ST_ADDR:  phase_len = ADDR_CYC;
         ST_MODE:  phase_len = MODE_CYC;
         ST_DUMMY: phase_len = DUMMY_CYC;
         default:  phase_len = 1;
      endcase
      last = (cnt == 4'(phase_len - 1));
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Phase sequencing plus the strobes that drive the byte pipeline.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      fetch      = 1'b0;
      advance    = 1'b0;
      cmd_bad    = 1'b0;
      if (ce_n) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  state_next = cont_mode ? ST_ADDR : ST_CMD;
            ST_CMD: begin
               if (ev && last) begin
                  state_next = cmd_ok ? ST_ADDR : ST_IGNORE;
                  cmd_bad    = ~cmd_ok;
               end
            end
            ST_ADDR:  if (ev && last) state_next = ST_MODE;
            ST_MODE: begin
               if (ev && last) begin
                  state_next = ST_DUMMY;
                  start      = 1'b1;
               end
            end
            ST_DUMMY: if (ev && last) state_next = ST_DATA;
            ST_DATA: begin
               fetch   = ev & nib_hi;
               advance = ev & ~nib_hi;
            end
            default:  state_next = state;
         endcase
      end
   end

   // Phase event counter; only runs inside the fixed-length header phases.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 4'd0;
      end else if (ce_n || !(state inside {ST_CMD, ST_ADDR, ST_MODE, ST_DUMMY})) begin
         cnt <= 4'd0;
      end else if (ev) begin
         cnt <= last ? 4'd0 : cnt + 4'd1;
      end
   end

   // Header shift registers, continuous-mode flag, nibble select and error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_sr    <= 7'd0;
         saddr     <= '0;
         mode_hi   <= 4'h0;
         nib_hi    <= 1'b1;
         cont_mode <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         cmd_err <= cmd_bad;
         if (state != ST_DATA) nib_hi <= 1'b1;
         else if (ev)          nib_hi <= ~nib_hi;
         if (ev) begin
            case (state)
               ST_CMD:  cmd_sr <= {cmd_sr[5:0], io_in[0]};
               ST_ADDR: saddr  <= {saddr[ADDR_W-5:0], io_in};
               ST_MODE: begin
                  if (!last) mode_hi   <= io_in;
                  else       cont_mode <= (mode_hi == CONT_NIB);
               end
               default: ;
            endcase
         end
      end
   end

   qspi_byte_prefetch #(
      .ADDR_W (ADDR_W)
   ) u_prefetch (
      .clk        (clk),
      .rst_n      (rst_n),
      .abort      (ce_n),
      .start      (start),
      .fetch      (fetch),
      .advance    (advance),
      .nib_hi     (nib_hi),
      .start_addr (saddr),
      .mem_rdata  (mem_rdata),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .nibble     (nibble)
   );

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Self-checking bench: acts as the QSPI reader and a synchronous backing
// memory, and compares returned bytes against an address-derived model.
module tb_qspi_flash_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sck;
   logic        ce_n;
   logic [3:0]  io_in;
   logic [3:0]  io_out;
   logic        io_oe;
   logic [23:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata = 8'h00;
   logic        cont_mode;
   logic        cmd_err;

   int checks   = 0;
   int failures = 0;
   int err_cnt  = 0;
   int rd_cnt   = 0;
   int oe_cnt   = 0;
   bit model_cont = 1'b0;

   always #5 clk = ~clk;

   qspi_flash_responder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sck       (sck),
      .ce_n      (ce_n),
      .io_in     (io_in),
      .io_out    (io_out),
      .io_oe     (io_oe),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_rdata (mem_rdata),
      .cont_mode (cont_mode),
      .cmd_err   (cmd_err)
   );

   // Backing memory: byte i holds i[7:0] ^ 8'h5A, data one clk after strobe.
   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem_addr[7:0] ^ 8'h5A;
   end

   // Pulse/level counters sampled mid-cycle.
   always @(negedge clk) begin
      if (cmd_err) err_cnt++;
      if (mem_rd)  rd_cnt++;
      if (io_oe)   oe_cnt++;
   end

   function automatic logic [7:0] expectByte(input logic [23:0] base, input int k);
      logic [23:0] a;
      a = base + 24'(k);
      return a[7:0] ^ 8'h5A;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One sck event: a low cycle, then a high cycle carrying nib; io_out is
   // sampled during the high cycle, just before the edge that forms the event.
   task automatic applyStimulus(input logic [3:0] nib, output logic [3:0] sampled);
      @(negedge clk);
      sck = 1'b0;
      @(negedge clk);
      sck     = 1'b1;
      io_in   = nib;
      sampled = io_out;
   endtask

   task automatic beginTxn();
      @(negedge clk);
      sck  = 1'b0;
      ce_n = 1'b0;
   endtask

   task automatic endTxn(input string tag);
      int rd_snap;
      @(negedge clk);
      sck   = 1'b0;
      ce_n  = 1'b1;
      io_in = 4'h0;
      @(negedge clk);
      checkOutput($sformatf("%s/oe_off", tag), io_oe, 0);
      rd_snap = rd_cnt;
      repeat (4) @(negedge clk);
      checkOutput($sformatf("%s/no_rd", tag), rd_cnt, rd_snap);
   endtask

   task automatic sendHeader(input string tag, input logic [23:0] addr, input logic [7:0] mode);
      logic [3:0] s;
      logic [7:0] cmd;
      cmd = 8'hEB;
      beginTxn();
      if (!model_cont)
         for (int i = 7; i >= 0; i--) applyStimulus({3'($urandom), cmd[i]}, s);
      for (int i = 5; i >= 0; i--) applyStimulus(addr[i*4 +: 4], s);
      applyStimulus(mode[7:4], s);
      applyStimulus(mode[3:0], s);
      model_cont = (mode[7:4] == 4'hA);
      @(negedge clk);
      sck = 1'b0;
      checkOutput($sformatf("%s/cont", tag), cont_mode, model_cont);
      repeat (4) applyStimulus(4'($urandom), s);
   endtask

   task automatic readBytes(input string tag, input logic [23:0] addr, input int nbytes);
      logic [3:0] hi, lo;
      for (int k = 0; k < nbytes; k++) begin
         applyStimulus(4'($urandom), hi);
         if (k == 0) checkOutput($sformatf("%s/oe", tag), io_oe, 1);
         applyStimulus(4'($urandom), lo);
         checkOutput($sformatf("%s/b%0d", tag, k), {hi, lo}, expectByte(addr, k));
      end
   endtask

   task automatic doRead(input string tag, input logic [23:0] addr, input logic [7:0] mode, input int nbytes);
      sendHeader(tag, addr, mode);
      readBytes(tag, addr, nbytes);
      endTxn(tag);
   endtask

   task automatic rawCmd(input string tag, input logic [7:0] cmd, input int extra);
      logic [3:0] s;
      beginTxn();
      for (int i = 7; i >= 0; i--) applyStimulus({3'($urandom), cmd[i]}, s);
      for (int i = 0; i < extra; i++) applyStimulus(4'($urandom), s);
      endTxn(tag);
   endtask

   initial begin
      int         e0, o0, n;
      logic [3:0] s;
      logic [23:0] addr;
      logic [7:0]  mode;
      logic [23:0] first_addr;
      logic [7:0]  first_mode;

      rst_n = 1'b0;
      sck   = 1'b0;
      ce_n  = 1'b1;
      io_in = 4'h0;
      repeat (3) @(negedge clk);
      checkOutput("rst/io_oe", io_oe, 0);
      checkOutput("rst/io_out", io_out, 0);
      checkOutput("rst/mem_rd", mem_rd, 0);
      checkOutput("rst/mem_addr", mem_addr, 0);
      checkOutput("rst/cont", cont_mode, 0);
      checkOutput("rst/cmd_err", cmd_err, 0);
      rst_n = 1'b1;

      // sck activity with ce_n high must be ignored
      repeat (10) begin
         @(negedge clk);
         sck   = ~sck;
         io_in = 4'($urandom);
      end
      sck = 1'b0;
      @(negedge clk);
      checkOutput("idle_sck/rd", rd_cnt, 0);
      checkOutput("idle_sck/err", err_cnt, 0);

      doRead("rd1", 24'h000100, 8'hA0, 16);
      checkOutput("rd1/err", err_cnt, 0);
      doRead("rd2", 24'h000230, 8'hA5, 16);
      checkOutput("rd2/err", err_cnt, 0);
      doRead("wrap", 24'hFFFFF8, 8'h00, 16);

      // not armed any more: an address-first header is decoded as command 0x08
      e0 = err_cnt;
      beginTxn();
      first_addr = 24'h000010;
      first_mode = 8'hA0;
      for (int i = 5; i >= 0; i--) applyStimulus(first_addr[i*4 +: 4], s);
      applyStimulus(first_mode[7:4], s);
      applyStimulus(first_mode[3:0], s);
      repeat (4) applyStimulus(4'($urandom), s);
      endTxn("addr_first");
      checkOutput("addr_first/err", err_cnt, e0 + 1);
      checkOutput("addr_first/cont", cont_mode, 0);

      e0 = err_cnt;
      o0 = oe_cnt;
      rawCmd("cmd03", 8'h03, 32);
      checkOutput("cmd03/err", err_cnt, e0 + 1);
      checkOutput("cmd03/oe", oe_cnt, o0);
      checkOutput("cmd03/cont", cont_mode, 0);

      doRead("early", 24'h000040, 8'hA0, 3);
      doRead("after", 24'h000010, 8'h00, 4);

      e0 = err_cnt;
      for (int t = 0; t < 6; t++) begin
         addr = 24'($urandom);
         mode = ($urandom_range(0, 1) == 1) ? {4'hA, 4'($urandom)} : 8'($urandom);
         n    = int'($urandom_range(1, 8));
         doRead($sformatf("rnd%0d", t), addr, mode, n);
      end
      checkOutput("rnd/err", err_cnt, e0);

      // asynchronous reset in the middle of the data phase
      sendHeader("midrst", 24'h000300, 8'hA0);
      readBytes("midrst", 24'h000300, 2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst/io_oe", io_oe, 0);
      checkOutput("midrst/io_out", io_out, 0);
      checkOutput("midrst/mem_rd", mem_rd, 0);
      checkOutput("midrst/mem_addr", mem_addr, 0);
      checkOutput("midrst/cont", cont_mode, 0);
      checkOutput("midrst/cmd_err", cmd_err, 0);
      @(negedge clk);
      sck   = 1'b0;
      ce_n  = 1'b1;
      rst_n = 1'b1;
      model_cont = 1'b0;
      repeat (2) @(negedge clk);
      doRead("postrst", 24'h000500, 8'h5A, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/qspi_flash_responder.md
Name: qspi_flash_responder

Overview:
- Synthesizable target (responder) end of the Quad I/O Fast Read (0xEB) link driven by the flash reader inside the AHB flash controller.
- Decodes command, address, mode and dummy phases from sck/ce_n/io, then streams nibbles back from a byte-wide synchronous backing memory.
- Used as an on-chip flash stand-in for FPGA prototyping and as a synthesizable bench target.
- Runs on the same clock as the reader; sck is a clock-synchronous level (toggling at most once per clk), not a clock.

Parameters:
- ADDR_W, 24, flash byte-address width; addresses wrap modulo 2^ADDR_W.
- CONT_NIB, 4'hA, mode high nibble that enables continuous-read mode.
- DUMMY_CYC, 4, number of sck events in the dummy phase.

Ports:
- clk        in   1       system clock (same clock as the reader)
- rst_n      in   1       asynchronous active-low reset
- sck        in   1       serial clock from the reader
- ce_n       in   1       chip enable, active low
- io_in      in   4       reader dout; command bits arrive on io_in[0]
- io_out     out  4       data nibble returned to the reader's din
- io_oe      out  1       responder drive enable
- mem_addr   out  ADDR_W  backing memory byte address
- mem_rd     out  1       backing memory read strobe; data valid 1 clk later
- mem_rdata  in   8       backing memory read data
- cont_mode  out  1       continuous-read mode armed
- cmd_err    out  1       1-clk pulse when an unsupported command is received

Behaviour:
- Event definition: ev = ~ce_n & sck at a posedge clk. All phase counting and sampling happens on ev only.
- Reset values: io_out=0, io_oe=0, mem_rd=0, mem_addr=0, cont_mode=0, cmd_err=0, state=IDLE.
- Reset asserted mid-transaction aborts immediately. After reset, the next transaction starts in CMD.
- States: IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE.
- IDLE: when ce_n is sampled low, go to ADDR if cont_mode=1, otherwise CMD. Phase counter clears.
- CMD, 8 events: shift io_in[0] MSB first.
  - On the 8th event, go to ADDR if the byte is 8'hEB.
  - Otherwise go to IGNORE and pulse cmd_err.
- ADDR, 6 events: shift io_in into saddr, high nibble first (saddr[23:20] first).
- MODE, 2 events: capture the mode byte, high nibble first.
  - On the 2nd event: cont_mode <= (mode[7:4]==CONT_NIB).
  - Same edge: mem_rd=1, mem_addr=saddr; then go to DUMMY.
- DUMMY, DUMMY_CYC events: the cycle after the mem_rd strobe loads mem_rdata into cur_byte. On the last event, go to DATA.
- DATA, unbounded:
  - io_oe=1.
  - io_out = nib_hi ? cur_byte[7:4] : cur_byte[3:0]; nib_hi=1 on entry.
  - On each ev, toggle nib_hi.
  - On the high-nibble ev: mem_rd=1 and mem_addr=ptr+1, where ptr holds the current byte address; the result lands in next_byte.
  - On the low-nibble ev: cur_byte <= next_byte, ptr <= ptr+1.
- Pointer arithmetic: ptr is ADDR_W bits and wraps silently from all-ones to 0.
- Timing contract: the reader samples the nibble for byte k at absolute events 20+2k (high) and 21+2k (low), counted from the CMD start. io_out must be stable during the full clk cycle before that event.
- IGNORE: io_oe=0; wait for ce_n high. cont_mode is unchanged.
- ce_n sampled high in any state:
  - Next state IDLE, io_oe=0 the same cycle, no mem_rd issued.
  - A mem_rd already in flight is discarded.
  - cont_mode is retained.
- sck toggling while ce_n is high is ignored.
- mem_rd is a single-clk pulse. At most one outstanding read.
- Continuous-mode transactions skip CMD only; ADDR, MODE, DUMMY and DATA are unchanged.

Decomposition:
- Shared package qspi_pkg:
  - state enum.
  - CMD_QIOR=8'hEB.
  - Phase lengths: CMD_CYC=8, ADDR_CYC=6, MODE_CYC=2.
  - CONT_NIB default.
- One natural sub-module, qspi_byte_prefetch:
  - holds cur_byte, next_byte and ptr;
  - issues mem_rd/mem_addr;
  - exposes the current nibble given nib_hi and advance strobes.
- The FSM and phase counter stay in the top module.

Test Plan:
- Memory byte i = i[7:0] ^ 8'h5A. Connect to the existing flash reader.
- After reset, rd with addr 24'h000100 → cmd 0xEB decoded, cont_mode=1 after the mode phase, reader line byte i = (8'h00+i)^8'h5A for i=0..15, reader done at counter 52.
- Second rd at 24'h000230 (reader starts at counter 8, no command) → responder enters ADDR directly, line bytes = (8'h30+i)^8'h5A, cmd_err stays 0.
- Raw stimulus: command 8'h03 then 32 sck events → cmd_err pulses once, io_oe stays 0, state IGNORE until ce_n rises, then IDLE.
- Read at 24'hFFFFF8 for 16 bytes → bytes 0..7 from 0xFFFFF8..0xFFFFFF, bytes 8..15 from 0x000000..0x000007.
- Mode byte 8'h00 → cont_mode=0. The next transaction must start with CMD; driving the address first produces cmd_err.
- Deassert ce_n after 3 data bytes → io_oe=0 next clk, no further mem_rd. A following transaction at 24'h000010 returns correct data.
- Assert rst_n low mid-DATA → all outputs return to reset values asynchronously and cont_mode=0.
